// File: rtl/board_pkg.sv
// Shared board geometry and controller state encoding for the game FSM, logic unit and RAM owner.
// Pure declarations: no latency, no flow control.
package board_pkg;
  localparam int COLS   = 7;
  localparam int ROWS   = 6;
  localparam int AW     = 3;
  localparam int SNAP_W = COLS * ROWS;

  typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DRAIN} state_t;
endpackage

// File: rtl/board_mem_ctrl_col_sequencer.sv
// Column counter stepping 0..COLS-1 for the clear and scan sequences.
// One column per advance; start reloads column 0 and takes precedence over advance.
module col_sequencer
  import board_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          advance,
  output logic [AW-1:0] col,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
    end else if (start) begin
      col <= '0;
    end else if (advance) begin
      col <= col + 1'b1;
    end
  end

  assign last = (col == AW'(COLS - 1));

endmodule

// File: rtl/board_mem_ctrl.sv
// Arbitrates the on/off and player board RAMs between the move port, board clear and board scan.
// Move access is granted combinationally in IDLE (read data next cycle); clear takes 8 cycles, scan 9.
module board_mem_ctrl
  import board_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              scan_req,
  input  logic              mv_req,
  input  logic              mv_we,
  input  logic [AW-1:0]     mv_addr,
  input  logic [ROWS-1:0]   mv_wdata_onoff,
  input  logic [ROWS-1:0]   mv_wdata_player,
  output logic              mv_gnt,
  output logic              mv_rvalid,
  output logic [ROWS-1:0]   mv_rdata_onoff,
  output logic [ROWS-1:0]   mv_rdata_player,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_we_onoff,
  output logic              ram_we_player,
  output logic [ROWS-1:0]   ram_wdata_onoff,
  output logic [ROWS-1:0]   ram_wdata_player,
  input  logic [ROWS-1:0]   ram_rdata_onoff,
  input  logic [ROWS-1:0]   ram_rdata_player,
  output logic [SNAP_W-1:0] scan_onoff,
  output logic [SNAP_W-1:0] scan_player,
  output logic              scan_done,
  output logic              clear_done,
  output logic              busy
);

  state_t        state, state_nxt;
  logic          clear_pend, scan_pend;
  logic          seq_start, seq_adv, seq_last, clear_fin;
  logic [AW-1:0] col;
  logic          mv_in_range, rd_oob, capture;

  col_sequencer u_seq (
    .clk     (clk),
    .reset   (reset),
    .start   (seq_start),
    .advance (seq_adv),
    .col     (col),
    .last    (seq_last)
  );

  assign mv_in_range = (mv_addr < AW'(COLS));
  assign mv_gnt      = mv_req && (state == IDLE) && !clear_pend;
  assign busy        = (state != IDLE) || clear_pend || scan_pend;
  // RAM data returned now belongs to the column addressed last cycle.
  assign capture     = ((state == SCAN) && (col != '0)) || (state == DRAIN);

  always_comb begin
    state_nxt        = state;
    seq_start        = 1'b0;
    seq_adv          = 1'b0;
    clear_fin        = 1'b0;
    ram_addr         = '0;
    ram_we_onoff     = 1'b0;
    ram_we_player    = 1'b0;
    ram_wdata_onoff  = '0;
    ram_wdata_player = '0;
    case (state)
      IDLE: begin
        if (clear_pend || clear_req) begin
          state_nxt = CLEAR;
          seq_start = 1'b1;
        end else if (mv_gnt) begin
          ram_addr         = mv_addr;
          ram_we_onoff     = mv_we && mv_in_range;
          ram_we_player    = mv_we && mv_in_range;
          ram_wdata_onoff  = mv_wdata_onoff;
          ram_wdata_player = mv_wdata_player;
        end else if (scan_pend || scan_req) begin
          state_nxt = SCAN;
          seq_start = 1'b1;
        end
      end
      CLEAR: begin
        ram_addr      = col;
        ram_we_onoff  = 1'b1;
        ram_we_player = 1'b1;
        seq_adv       = 1'b1;
        if (seq_last) begin
          state_nxt = IDLE;
          clear_fin = 1'b1;
        end
      end
      SCAN: begin
        ram_addr = col;
        seq_adv  = 1'b1;
        if (seq_last) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      clear_pend  <= 1'b1;
      scan_pend   <= 1'b0;
      mv_rvalid   <= 1'b0;
      rd_oob      <= 1'b0;
      scan_done   <= 1'b0;
      clear_done  <= 1'b0;
      scan_onoff  <= '0;
      scan_player <= '0;
    end else begin
      state      <= state_nxt;
      clear_pend <= (state == IDLE && state_nxt == CLEAR) ? 1'b0 : (clear_pend || clear_req);
      scan_pend  <= (state == IDLE && state_nxt == SCAN)  ? 1'b0 : (scan_pend || scan_req);
      mv_rvalid  <= mv_gnt && !mv_we;
      rd_oob     <= !mv_in_range;
      scan_done  <= (state == DRAIN);
      clear_done <= clear_fin;
      if (clear_fin) begin
        scan_onoff  <= '0;
        scan_player <= '0;
      end else if (capture) begin
        scan_onoff  <= {ram_rdata_onoff,  scan_onoff[SNAP_W-1:ROWS]};
        scan_player <= {ram_rdata_player, scan_player[SNAP_W-1:ROWS]};
      end
    end
  end

  assign mv_rdata_onoff  = (mv_rvalid && !rd_oob) ? ram_rdata_onoff  : '0;
  assign mv_rdata_player = (mv_rvalid && !rd_oob) ? ram_rdata_player : '0;

endmodule

// File: doc/board_mem_ctrl.md
# board_mem_ctrl

Single owner of the two 7×6 board RAMs: the on/off board and the player board. It shares them between three requesters:
- the game FSM's single-column move port;
- a board-clear sequencer, which zeroes all 7 columns;
- a board-scan sequencer, which reads all 7 columns into a 42-bit snapshot for the game logic unit.

It sits between the game FSM/game logic unit and the RAM pair and replaces ad-hoc address muxing in the FSM.

## Interface
- COLS, 7, number of columns (RAM depth used)
- ROWS, 6, bits per column word
- AW, 3, address width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear_req  in  1  single-cycle pulse; latched as pending
- scan_req  in  1  single-cycle pulse; latched as pending
- mv_req  in  1  move-port request; level, held until mv_gnt
- mv_we  in  1  1 = write column, 0 = read column
- mv_addr  in  AW  column index
- mv_wdata_onoff, mv_wdata_player  in  ROWS  write data
- mv_gnt  out  1  move access performed this cycle
- mv_rvalid  out  1  read data valid (one cycle after a granted read)
- mv_rdata_onoff, mv_rdata_player  out  ROWS  read data
- ram_addr  out  AW; ram_we_onoff, ram_we_player  out  1; ram_wdata_onoff, ram_wdata_player  out  ROWS
- ram_rdata_onoff, ram_rdata_player  in  ROWS  synchronous RAM read data (valid cycle after address)
- scan_onoff, scan_player  out  COLS*ROWS  snapshot; column k occupies bits [ROWS*k +: ROWS]
- scan_done, clear_done  out  1  single-cycle completion pulses
- busy  out  1  state≠IDLE or any pending flag set

## Operation
- States:
  - IDLE;
  - CLEAR: col 0..6 written with 0 on both RAMs;
  - SCAN: col 0..6 addressed, reads only;
  - DRAIN: captures the last read.
- Pending flags:
  - clear_pend is set by a clear_req pulse and cleared on entry to CLEAR.
  - scan_pend is set by a scan_req pulse and cleared on entry to SCAN.
  - A request arriving during its own sequence re-sets the flag; it runs again afterwards.
- IDLE priority: clear_pend > mv_req > scan_pend.
  - A granted move is a single cycle and the state stays IDLE. The move port can therefore starve the scan; the FSM does not hold mv_req continuously.
- Move access:
  - mv_gnt = mv_req & IDLE & !clear_pend, combinational.
  - When granted, the RAM is driven with mv_addr/data, and ram_we_* = mv_we on both RAMs.
  - mv_addr ≥ COLS: still granted, write suppressed, read returns 0 with mv_rvalid.
- mv_rdata_* are the RAM data passed through, qualified by mv_rvalid. mv_rdata_* are 0 when mv_rvalid=0.
- Scan: column k data is captured into the snapshot the cycle after it is addressed. The snapshot holds its value until the next scan or clear.
- CLEAR also zeroes the snapshot registers on exit.
- When not granted or sequencing: ram_addr=0, ram_we_*=0, ram_wdata_*=0.
- Reset:
  - state=IDLE, counter=0, scan_pend=0, clear_pend=1, so the board is always zeroed after reset.
  - Snapshot=0; mv_rvalid, scan_done, clear_done=0.
  - busy=1 while clear_pend is set.
- Reset mid-sequence aborts it immediately and restarts with a full clear.

## Timing
- Request pulse at cycle T, with the block IDLE and no higher-priority request.
- Clear:
  - CLEAR during T+1..T+7, address k at T+1+k.
  - clear_done=1 and state=IDLE at T+8.
- Scan:
  - SCAN during T+1..T+7, address k at T+1+k.
  - DRAIN at T+8.
  - scan_done=1 at T+9, with the snapshot fully updated in that same cycle. IDLE at T+9.
- Move read granted at cycle G: mv_rvalid=1 and data valid at G+1.
- Move writes complete at the G clock edge.
- Simultaneous clear_req and scan_req: clear runs first, then scan immediately (IDLE for 1 cycle between).
- mv_req during CLEAR/SCAN/DRAIN: mv_gnt=0, request is held, granted first IDLE cycle without clear_pend.
- busy falls in the cycle the done pulse is high, if nothing is pending.

## Structure
- Package board_pkg:
  - COLS, ROWS, AW, SNAP_W = COLS*ROWS;
  - state enum {IDLE, CLEAR, SCAN, DRAIN}.
  - The game FSM and the logic unit import it.
- Sub-module col_sequencer: 3-bit column counter with start/advance, last (k==COLS-1) flag and sync reset. Shared by CLEAR and SCAN.
- Top holds the arbiter, pending flags, snapshot shift-in and output muxing.

## Test plan
- Reset released, no requests → CLEAR writes 0 to addr 0..6 on both RAMs; clear_done at 8th cycle after reset release; busy low next cycle.
- RAM model preloaded with col k = k (both boards), scan_req at T → scan_done at T+9; scan_onoff = {6'd6,…,6'd1,6'd0}.
- mv write addr 3 data 6'h15, then read addr 3 → mv_gnt both cycles; mv_rvalid next cycle with 6'h15.
- scan_req and mv_req same cycle in IDLE → move granted first; scan starts next cycle; scan_done 10 cycles after the request.
- clear_req during scan (cycle T+4) → scan completes normally (scan_done T+9), CLEAR follows, then the snapshot is zero.
- mv_addr=7 write → granted, ram_we_* stay 0; read at addr 7 returns 0 with mv_rvalid.
